// File: rtl/arbitro_pkg.sv
// Shared types, defaults and the round-robin pick helper for arbitro_registrador.
package arbitro_pkg;

    localparam int unsigned N_REQ_DEFAULT = 4;
    localparam int unsigned WIDTH_DEFAULT = 4;
    // Widest requester vector the pick helper handles.
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StAck
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    // First requester at or after ptr with req set, wrapping around n.
    function automatic pick_t rr_pick(input int unsigned n, input logic [2:0] ptr,
                                      input logic [MAX_REQ-1:0] req);
        pick_t       res;
        int unsigned j;
        logic [2:0]  jj;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j  = (32'(ptr) + k) % n;
            jj = 3'(j);
            if (k < n && !res.valid && req[jj]) begin
                res.valid = 1'b1;
                res.idx   = jj;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/registrador_n.sv
// WIDTH-bit storage register with load enable and asynchronous active-high reset.
module registrador_n #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d whenever the arbiter enables a write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/arbitro_registrador.sv
// Round-robin arbiter and write sequencer for a shared WIDTH-bit register.
// Optional burst lock feature: define ARBITRO_REGISTRADOR_LOCK_EN.
module arbitro_registrador
    import arbitro_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] dado,
`ifdef ARBITRO_REGISTRADOR_LOCK_EN
    input  logic [N_REQ-1:0]       lock,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic [IDW-1:0]         dono,
    output logic                   ocupado
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     winner_q, winner_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     dono_q, dono_d;
    logic [IDW-1:0]     ptr_next;
    logic [MAX_REQ-1:0] req_ext;
    pick_t              pick;
    logic               win_req;
    logic               load;
    logic [N_REQ-1:0]   win_onehot;
    logic               unused_pick_bits;

`ifdef ARBITRO_REGISTRADOR_LOCK_EN
    logic [IDW-1:0]     burst_q, burst_d;
    logic               burst_ok;
`endif

    assign req_ext          = MAX_REQ'(req);
    assign pick             = rr_pick(N_REQ, 3'(ptr_q), req_ext);
    // Upper index bits are always zero when N_REQ is small.
    assign unused_pick_bits = ^pick.idx;
    assign win_req          = req[winner_q];
    assign ptr_next         = (winner_q == IDW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
    assign win_onehot       = N_REQ'(1) << winner_q;

`ifdef ARBITRO_REGISTRADOR_LOCK_EN
    assign burst_ok = lock[winner_q] && win_req && (burst_q < IDW'(N_REQ - 1));
`endif

    // Next-state logic: arbitration in idle, write or abort in grant, rotation in ack.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        ptr_d    = ptr_q;
        dono_d   = dono_q;
        load     = 1'b0;
`ifdef ARBITRO_REGISTRADOR_LOCK_EN
        burst_d  = burst_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick.valid) begin
                    winner_d = IDW'(pick.idx);
                    state_d  = StGrant;
                end
            end
            StGrant: begin
                if (win_req) begin
                    load    = 1'b1;
                    dono_d  = winner_q;
                    state_d = StAck;
                end else begin
                    // Winner withdrew: abort without writing or rotating.
                    state_d = StIdle;
`ifdef ARBITRO_REGISTRADOR_LOCK_EN
                    burst_d = '0;
`endif
                end
            end
            StAck: begin
`ifdef ARBITRO_REGISTRADOR_LOCK_EN
                if (burst_ok) begin
                    state_d = StGrant;
                    burst_d = burst_q + 1'b1;
                end else begin
                    state_d = StIdle;
                    ptr_d   = ptr_next;
                    burst_d = '0;
                end
`else
                state_d = StIdle;
                ptr_d   = ptr_next;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State, winner, rotation pointer and last-writer registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            winner_q <= '0;
            ptr_q    <= '0;
            dono_q   <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            dono_q   <= dono_d;
        end
    end

`ifdef ARBITRO_REGISTRADOR_LOCK_EN
    // Consecutive locked writes granted to the current winner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    // Outputs decoded from registered state only.
    always_comb begin
        gnt     = (state_q != StIdle) ? win_onehot : '0;
        ack     = (state_q == StAck) ? win_onehot : '0;
        ocupado = (state_q != StIdle);
        dono    = dono_q;
    end

    registrador_n #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .d     (dado[winner_q*WIDTH +: WIDTH]),
        .q     (q)
    );

    logic unused_ok;
    assign unused_ok = unused_pick_bits;

endmodule

// File: tb/tb_arbitro_registrador.sv
// Self-checking bench for arbitro_registrador: vector tables, hand sequences, random vs model.
module tb_arbitro_registrador;

    localparam int N = 4;
    localparam int W = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] dado;
`ifdef ARBITRO_REGISTRADOR_LOCK_EN
    logic [N-1:0]   lock;
`endif
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic [1:0]     dono;
    logic           ocupado;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    arbitro_registrador #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .dado    (dado),
`ifdef ARBITRO_REGISTRADOR_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .ack     (ack),
        .q       (q),
        .dono    (dono),
        .ocupado (ocupado)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] g;
        logic [N-1:0] a;
        logic [W-1:0] qv;
        logic [1:0]   d;
        logic         o;
    } vec_t;

    typedef struct {
        logic         v;
        logic [N-1:0] g;
        logic [N-1:0] a;
        logic [W-1:0] qv;
        logic [1:0]   d;
    } slot_t;

    vec_t  tbl[$];
    slot_t s1, s2;
    int    mptr;
    logic [W-1:0] mq;
    logic [1:0]   md;
    logic [N-1:0] drop;
    logic [W-1:0] rdata [N];

    function automatic vec_t v(input logic [N-1:0] r, input logic [N-1:0] g,
                               input logic [N-1:0] a, input logic [W-1:0] qv,
                               input logic [1:0] d, input logic o);
        vec_t x;
        x.req = r; x.g = g; x.a = a; x.qv = qv; x.d = d; x.o = o;
        return x;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Spec rule: first requester at or after the pointer with req set, wrapping.
    function automatic int model_pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] eg, input logic [N-1:0] ea,
                       input logic [W-1:0] eq, input logic [1:0] ed, input logic eo);
        checks++;
        if (gnt !== eg || ack !== ea || q !== eq || dono !== ed || ocupado !== eo) begin
            errors++;
            $display("FAIL %s @%0t: got gnt=%b ack=%b q=%h dono=%0d ocupado=%b, want gnt=%b ack=%b q=%h dono=%0d ocupado=%b",
                     name, $time, gnt, ack, q, dono, ocupado, eg, ea, eq, ed, eo);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        dado  = '0;
`ifdef ARBITRO_REGISTRADOR_LOCK_EN
        lock  = '0;
`endif
        drop  = '0;
        s1.v  = 1'b0;
        s2.v  = 1'b0;
        mptr  = 0;
        mq    = '0;
        md    = '0;
        @(negedge clock);
        chk("reset_held", '0, '0, '0, 2'd0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic run_rows(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clock);
            #1 req = tbl[i].req;
            @(negedge clock);
            chk($sformatf("%s[%0d]", name, i), tbl[i].g, tbl[i].a, tbl[i].qv, tbl[i].d, tbl[i].o);
        end
    endtask

    task automatic run_random(input int cycles, input bit raise);
        slot_t cur;
        int    w;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (drop[i]) begin
                    req[i]  = 1'b0;
                    drop[i] = 1'b0;
                end else if (raise && !req[i] && $urandom_range(0, 2) == 0) begin
                    rdata[i]        = W'($urandom);
                    dado[i*W +: W]  = rdata[i];
                    req[i]          = 1'b1;
                end
            end
            @(negedge clock);
            cur  = s1;
            s1   = s2;
            s2.v = 1'b0;
            if (cur.v) begin
                chk("random_busy", cur.g, cur.a, cur.qv, cur.d, 1'b1);
                if (cur.a != '0) begin
                    mq = cur.qv;
                    md = cur.d;
                    drop[cur.d] = 1'b1;
                end
            end else begin
                chk("random_idle", '0, '0, mq, md, 1'b0);
                if (req != '0) begin
                    w     = model_pick(mptr, req);
                    s1.v  = 1'b1; s1.g = onehot(w); s1.a = '0;        s1.qv = mq;       s1.d = md;
                    s2.v  = 1'b1; s2.g = onehot(w); s2.a = onehot(w); s2.qv = rdata[w]; s2.d = 2'(w);
                    mptr  = (w + 1) % N;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        dado  = '0;
`ifdef ARBITRO_REGISTRADOR_LOCK_EN
        lock  = '0;
`endif
        drop  = '0;

        // Idle after reset, then a single request from requester 0.
        do_reset();
        dado[3:0] = 4'b1011;
        tbl.delete();
        for (int i = 0; i < 5; i++) tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0));
        tbl.push_back(v(4'h1, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0));
        tbl.push_back(v(4'h1, 4'h1, 4'h0, 4'h0, 2'd0, 1'b1));
        tbl.push_back(v(4'h1, 4'h1, 4'h1, 4'hB, 2'd0, 1'b1));
        tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'hB, 2'd0, 1'b0));
        run_rows("single");

        // Full contention: rotation 0,1,2,3,0.
        do_reset();
        dado = 16'hDCBA;
        tbl.delete();
        tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0));
        tbl.push_back(v(4'hF, 4'h1, 4'h0, 4'h0, 2'd0, 1'b1));
        tbl.push_back(v(4'hF, 4'h1, 4'h1, 4'hA, 2'd0, 1'b1));
        tbl.push_back(v(4'hE, 4'h0, 4'h0, 4'hA, 2'd0, 1'b0));
        tbl.push_back(v(4'hF, 4'h2, 4'h0, 4'hA, 2'd0, 1'b1));
        tbl.push_back(v(4'hF, 4'h2, 4'h2, 4'hB, 2'd1, 1'b1));
        tbl.push_back(v(4'hD, 4'h0, 4'h0, 4'hB, 2'd1, 1'b0));
        tbl.push_back(v(4'hF, 4'h4, 4'h0, 4'hB, 2'd1, 1'b1));
        tbl.push_back(v(4'hF, 4'h4, 4'h4, 4'hC, 2'd2, 1'b1));
        tbl.push_back(v(4'hB, 4'h0, 4'h0, 4'hC, 2'd2, 1'b0));
        tbl.push_back(v(4'hF, 4'h8, 4'h0, 4'hC, 2'd2, 1'b1));
        tbl.push_back(v(4'hF, 4'h8, 4'h8, 4'hD, 2'd3, 1'b1));
        tbl.push_back(v(4'h7, 4'h0, 4'h0, 4'hD, 2'd3, 1'b0));
        tbl.push_back(v(4'hF, 4'h1, 4'h0, 4'hD, 2'd3, 1'b1));
        tbl.push_back(v(4'hF, 4'h1, 4'h1, 4'hA, 2'd0, 1'b1));
        tbl.push_back(v(4'hE, 4'h0, 4'h0, 4'hA, 2'd0, 1'b0));
        run_rows("contention");

        // Write by 1 moves ptr to 2; requester 2 aborts; ptr must stay at 2.
        do_reset();
        dado = 16'hE930;
        tbl.delete();
        tbl.push_back(v(4'h2, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0));
        tbl.push_back(v(4'h2, 4'h2, 4'h0, 4'h0, 2'd0, 1'b1));
        tbl.push_back(v(4'h2, 4'h2, 4'h2, 4'h3, 2'd1, 1'b1));
        tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h3, 2'd1, 1'b0));
        tbl.push_back(v(4'h4, 4'h0, 4'h0, 4'h3, 2'd1, 1'b0));
        tbl.push_back(v(4'h0, 4'h4, 4'h0, 4'h3, 2'd1, 1'b1));
        tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h3, 2'd1, 1'b0));
        tbl.push_back(v(4'hC, 4'h0, 4'h0, 4'h3, 2'd1, 1'b0));
        tbl.push_back(v(4'hC, 4'h4, 4'h0, 4'h3, 2'd1, 1'b1));
        tbl.push_back(v(4'hC, 4'h4, 4'h4, 4'h9, 2'd2, 1'b1));
        tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h9, 2'd2, 1'b0));
        run_rows("abort");

        // Reset during GRANT discards the write; the held request then completes.
        dado[7:4] = 4'b0110;
        @(posedge clock);
        #1 req = 4'b0010;
        @(negedge clock);
        chk("rstmid_idle", 4'h0, 4'h0, 4'h9, 2'd2, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk("rstmid_grant", 4'h2, 4'h0, 4'h9, 2'd2, 1'b1);
        #2 reset = 1'b1;
        #1 chk("rstmid_asserted", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rstmid_after_idle", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk("rstmid_after_grant", 4'h2, 4'h0, 4'h0, 2'd0, 1'b1);
        @(posedge clock);
        @(negedge clock);
        chk("rstmid_after_ack", 4'h2, 4'h2, 4'h6, 2'd1, 1'b1);
        @(posedge clock);
        #1 req = 4'b0000;
        @(negedge clock);
        chk("rstmid_done", 4'h0, 4'h0, 4'h6, 2'd1, 1'b0);

        // Random traffic against the reference model, then drain.
        do_reset();
        run_random(400, 1'b1);
        run_random(30, 1'b0);
        checks++;
        if (req !== '0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL drain: got req=%b ocupado=%b, want req=0000 ocupado=0", req, ocupado);
        end

`ifdef ARBITRO_REGISTRADOR_LOCK_EN
        // Locked burst: requester 0 writes 4 times, 2 cycles apart, then 1 is served.
        do_reset();
        dado = 16'h0021;
        lock = 4'b0001;
        @(posedge clock);
        #1 req = 4'b0011;
        @(negedge clock);
        chk("lock_idle", 4'h0, 4'h0, 4'h0, 2'd0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("lock_grant%0d", b), 4'h1, 4'h0, (b == 0) ? 4'h0 : 4'h1, 2'd0, 1'b1);
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("lock_ack%0d", b), 4'h1, 4'h1, 4'h1, 2'd0, 1'b1);
        end
        @(posedge clock);
        #1 req = 4'b0010;
        @(negedge clock);
        chk("lock_limit_idle", 4'h0, 4'h0, 4'h1, 2'd0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk("lock_next_grant", 4'h2, 4'h0, 4'h1, 2'd0, 1'b1);
        @(posedge clock);
        @(negedge clock);
        chk("lock_next_ack", 4'h2, 4'h2, 4'h2, 2'd1, 1'b1);
        @(posedge clock);
        #1 req = 4'b0000;
        lock = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
